agm: RTL and testbench

// - Address generator for an asymmetric dual-port buffer RAM: port A is 2048 x 8-bit (write side),

---
 rtl/agm_pkg.sv | 15 +
 rtl/agm_ptr.sv | 24 ++
 rtl/agm.sv | 69 ++++++
 tb/tb_agm.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/agm_pkg.sv
// agm_pkg: shared constants for the asymmetric-RAM address generator.
// - AW_A_DEF : default port-A (byte, write) address width
// - AW_B_DEF : default port-B (word, read) address width, always AW_A-2
// - RATIO    : bytes per port-B word
// - RATIO_SH : log2(RATIO), used to scale the word pointer to bytes
// - LVL_W    : occupancy width for the default geometry (0..2**AW_A inclusive)
package agm_pkg;

  localparam int AW_A_DEF = 11;
  localparam int AW_B_DEF = 9;
  localparam int RATIO    = 4;
  localparam int RATIO_SH = 2;
  localparam int LVL_W    = AW_A_DEF + 1;

endpackage

// File: rtl/agm_ptr.sv
// agm_ptr: enable-gated wrapping counter with synchronous active-low clear.
// The MSB acts as the wrap bit when the counter is used as a FIFO pointer.
// Ports:
// - clk   : rising-edge clock
// - reset : synchronous clear, active low (takes priority over en)
// - en    : advance by one on the next rising edge
// - ptr   : registered count, wraps from all-ones to zero
module agm_ptr #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!reset)
      ptr <= '0;
    else if (en)
      ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/agm.sv
// agm: address generator for an asymmetric dual-port buffer RAM.
// Port A is the byte-wide write side, port B the 32-bit read side; one B word
// covers four consecutive A bytes. The two pointers behave like a FIFO so reads
// never overtake writes and writes never overwrite unread bytes.
// Ports:
// - Writeclk : single clock, rising edge
// - reset    : synchronous clear, active low
// - Enwr     : write request, advances addra by one byte when not full
// - Enrd     : read request, advances addrb by one word when not empty
// - addra    : port-A byte address (registered)
// - addrb    : port-B word address (registered)
// - full     : no free byte left
// - empty    : fewer than four unread bytes
// - level    : unread bytes, 0..2**AW_A
module agm
  import agm_pkg::*;
#(
  parameter int AW_A = AW_A_DEF,
  parameter int AW_B = AW_B_DEF
) (
  input  logic            Writeclk,
  input  logic            reset,
  input  logic            Enwr,
  input  logic            Enrd,
  output logic [AW_A-1:0] addra,
  output logic [AW_B-1:0] addrb,
  output logic            full,
  output logic            empty,
  output logic [AW_A:0]   level
);

  // Occupancy when every byte is unread: only the wrap bit of the difference set.
  localparam logic [AW_A:0] FULL_LVL  = {1'b1, {AW_A{1'b0}}};
  localparam logic [AW_A:0] WORD_LVL  = (AW_A+1)'(RATIO);

  logic [AW_A:0] wr_ptr;
  logic [AW_B:0] rd_ptr;
  logic          wr_go;
  logic          rd_go;

  // Accept decisions use flags derived from the pre-edge pointers, so a
  // simultaneous write and read both land on the same edge.
  assign wr_go = Enwr && !full;
  assign rd_go = Enrd && !empty;

  agm_ptr #(.W(AW_A+1)) u_wr_ptr (
    .clk   (Writeclk),
    .reset (reset),
    .en    (wr_go),
    .ptr   (wr_ptr)
  );

  agm_ptr #(.W(AW_B+1)) u_rd_ptr (
    .clk   (Writeclk),
    .reset (reset),
    .en    (rd_go),
    .ptr   (rd_ptr)
  );

  // Read pointer scaled to bytes; the subtraction wraps modulo 2**(AW_A+1),
  // which keeps the level correct across pointer wrap-around.
  assign level = wr_ptr - {rd_ptr, {RATIO_SH{1'b0}}};
  assign full  = (level == FULL_LVL);
  assign empty = (level < WORD_LVL);

  assign addra = wr_ptr[AW_A-1:0];
  assign addrb = rd_ptr[AW_B-1:0];

endmodule

// File: tb/tb_agm.sv
// tb_agm: self-checking bench for agm. A byte-count reference model (occupancy,
// write byte address, read word address as plain integers) is advanced on each
// rising edge and compared against the DUT shortly after the edge.
module tb_agm;

  logic        Writeclk;
  logic        reset;
  logic        Enwr;
  logic        Enrd;
  logic [10:0] addra;
  logic [8:0]  addrb;
  logic        full;
  logic        empty;
  logic [11:0] level;

  int checks;
  int fails;
  int cyc;

  // Reference model state.
  int m_level;
  int m_wa;
  int m_rb;

  agm dut (
    .Writeclk (Writeclk),
    .reset    (reset),
    .Enwr     (Enwr),
    .Enrd     (Enrd),
    .addra    (addra),
    .addrb    (addrb),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  initial Writeclk = 1'b0;
  always #5 Writeclk = ~Writeclk;

  logic [33:0] dut_vec;
  assign dut_vec = {addra, addrb, full, empty, level};

  function automatic logic [33:0] exp_vec();
    logic [10:0] a;
    logic [8:0]  b;
    logic [11:0] l;
    a = 11'(m_wa);
    b = 9'(m_rb);
    l = 12'(m_level);
    return {a, b, (m_level == 2048), (m_level < 4), l};
  endfunction

  function automatic string vstr(logic [33:0] v);
    return $sformatf("addra=%0d addrb=%0d full=%b empty=%b level=%0d",
                     v[33:23], v[22:14], v[13], v[12], v[11:0]);
  endfunction

  // One rising edge: the model consumes the inputs the DUT saw at that edge,
  // then the bench settles 1ns past the edge for sampling.
  task automatic tick();
    bit aw, ar;
    @(posedge Writeclk);
    cyc++;
    if (!reset) begin
      m_level = 0; m_wa = 0; m_rb = 0;
    end else begin
      aw = Enwr && (m_level < 2048);
      ar = Enrd && (m_level >= 4);
      if (aw) begin m_wa = (m_wa + 1) % 2048; m_level += 1; end
      if (ar) begin m_rb = (m_rb + 1) % 512;  m_level -= 4; end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; Enwr = 1'b1; Enrd = 1'b1;
    tick(); tick();
    checks++;
    if (dut_vec !== {11'd0, 9'd0, 1'b0, 1'b1, 12'd0}) begin
      fails++;
      $display("FAIL reset_state: got %s, want addra=0 addrb=0 full=0 empty=1 level=0", vstr(dut_vec));
    end
  endtask

  task automatic test_steady();
    int max_lvl;
    reset = 1'b1; Enwr = 1'b1; Enrd = 1'b1;
    max_lvl = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++;
        $display("FAIL steady_cyc%0d: got %s, want %s", i, vstr(dut_vec), vstr(exp_vec()));
      end
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (i == 3) begin
        checks++;
        if (addra !== 11'd4 || addrb !== 9'd0) begin
          fails++;
          $display("FAIL steady_before_read: got addra=%0d addrb=%0d, want addra=4 addrb=0", addra, addrb);
        end
      end
      if (i == 4) begin
        checks++;
        if (addrb !== 9'd1) begin
          fails++;
          $display("FAIL steady_first_read: got addrb=%0d, want 1", addrb);
        end
      end
    end
    checks++;
    if (max_lvl > 7) begin
      fails++;
      $display("FAIL steady_max_level: got %0d, want <= 7", max_lvl);
    end
  endtask

  task automatic test_fill();
    reset = 1'b0; tick();
    reset = 1'b1; Enwr = 1'b1; Enrd = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++;
        $display("FAIL fill_cyc%0d: got %s, want %s", i, vstr(dut_vec), vstr(exp_vec()));
      end
    end
    checks++;
    if (dut_vec !== {11'd0, 9'd0, 1'b1, 1'b0, 12'd2048}) begin
      fails++;
      $display("FAIL fill_full: got %s, want addra=0 addrb=0 full=1 empty=0 level=2048", vstr(dut_vec));
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (addra !== 11'd0 || level !== 12'd2048 || full !== 1'b1) begin
      fails++;
      $display("FAIL fill_overwrite: got %s, want addra=0 full=1 level=2048", vstr(dut_vec));
    end
  endtask

  task automatic test_drain();
    Enwr = 1'b0; Enrd = 1'b1;
    for (int i = 0; i < 512; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++;
        $display("FAIL drain_cyc%0d: got %s, want %s", i, vstr(dut_vec), vstr(exp_vec()));
      end
      if (i == 510) begin
        checks++;
        if (addrb !== 9'd511) begin
          fails++;
          $display("FAIL drain_last_word: got addrb=%0d, want 511", addrb);
        end
      end
    end
    checks++;
    if (dut_vec !== {11'd0, 9'd0, 1'b0, 1'b1, 12'd0}) begin
      fails++;
      $display("FAIL drain_empty: got %s, want addra=0 addrb=0 full=0 empty=1 level=0", vstr(dut_vec));
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (addrb !== 9'd0 || level !== 12'd0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL drain_underflow: got %s, want addrb=0 empty=1 level=0", vstr(dut_vec));
    end
  endtask

  task automatic test_partial();
    reset = 1'b0; Enwr = 1'b0; Enrd = 1'b0; tick();
    reset = 1'b1; Enwr = 1'b1;
    tick(); tick(); tick();
    Enwr = 1'b0; Enrd = 1'b1;
    tick(); tick();
    checks++;
    if (addrb !== 9'd0 || level !== 12'd3 || empty !== 1'b1) begin
      fails++;
      $display("FAIL partial_hold: got %s, want addrb=0 level=3 empty=1", vstr(dut_vec));
    end
    Enwr = 1'b1; Enrd = 1'b1;
    tick();
    checks++;
    if (addrb !== 9'd0 || level !== 12'd4 || empty !== 1'b0) begin
      fails++;
      $display("FAIL partial_fourth: got %s, want addrb=0 level=4 empty=0", vstr(dut_vec));
    end
    Enwr = 1'b0;
    tick();
    checks++;
    if (addrb !== 9'd1 || level !== 12'd0) begin
      fails++;
      $display("FAIL partial_read: got %s, want addrb=1 level=0", vstr(dut_vec));
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b0; Enwr = 1'b0; Enrd = 1'b0; tick();
    reset = 1'b1; Enwr = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    Enwr = 1'b0; Enrd = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (addra !== 11'd100 || addrb !== 9'd20 || level !== 12'd20) begin
      fails++;
      $display("FAIL midrst_setup: got %s, want addra=100 addrb=20 level=20", vstr(dut_vec));
    end
    reset = 1'b0; Enwr = 1'b1; Enrd = 1'b1;
    tick();
    checks++;
    if (dut_vec !== {11'd0, 9'd0, 1'b0, 1'b1, 12'd0}) begin
      fails++;
      $display("FAIL midrst_clear: got %s, want addra=0 addrb=0 full=0 empty=1 level=0", vstr(dut_vec));
    end
  endtask

  task automatic test_random();
    reset = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      // Bias writes in alternating phases so occupancy sweeps toward both ends.
      if ((i / 600) % 2 == 0) begin
        Enwr = ($urandom_range(0, 9) < 8);
        Enrd = ($urandom_range(0, 9) < 2);
      end else begin
        Enwr = ($urandom_range(0, 9) < 2);
        Enrd = ($urandom_range(0, 9) < 6);
      end
      reset = ($urandom_range(0, 499) != 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++;
        $display("FAIL random_cyc%0d: got %s, want %s", i, vstr(dut_vec), vstr(exp_vec()));
      end
    end
  endtask

  initial begin
    checks = 0; fails = 0; cyc = 0;
    m_level = 0; m_wa = 0; m_rb = 0;
    reset = 1'b0; Enwr = 1'b0; Enrd = 1'b0;
    @(negedge Writeclk);
    test_reset();
    test_steady();
    test_fill();
    test_drain();
    test_partial();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
